// File: rtl/load_store_unit_pkg.sv
// Shared types and default widths for the load/store unit.
package lsu_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 4;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus between the execute stage (master) and the load/store unit (slave).
interface load_store_unit_if
  import lsu_pkg::*;
();

  // A beat transfers on a rising clock edge where valid && ready; the sender
  // holds valid and its payload stable until that edge.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic              store_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_last, store_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len, resp_ready,
    output req_ready, resp_valid, resp_data, resp_last, store_done
  );

endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage driving a 256x8 data memory: memset-style store bursts, registered load bursts.
// Optional LSU_FAULT_EN adds a fault pulse for requests that would run past the top of memory.
module load_store_unit
  import lsu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output lsu_state_t          dbg_state
`ifdef LSU_FAULT_EN
    ,
    output logic                fault
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [LEN_W-1:0]  CNT_ONE  = 1;

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_last_q, resp_last_d;
    logic              store_done_q, store_done_d;
    logic              req_ready;
    logic              range_fault;

`ifdef LSU_FAULT_EN
    logic              fault_q, fault_d;
    logic [ADDR_W:0]   end_addr;

    // Carry out of start+len means the burst would cross the top of memory.
    assign end_addr    = {1'b0, bus.req_addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, bus.req_len};
    assign range_fault = end_addr[ADDR_W];
`else
    assign range_fault = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q & ~bus.resp_ready;
        resp_data_d  = resp_data_q;
        resp_last_d  = resp_last_q;
        store_done_d = 1'b0;
        req_ready    = 1'b0;
`ifdef LSU_FAULT_EN
        fault_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready = ~resp_valid_q;
                if (bus.req_valid && req_ready) begin
                    if (range_fault) begin
`ifdef LSU_FAULT_EN
                        fault_d = 1'b1;
`endif
                    end else begin
                        addr_d  = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        cnt_d   = bus.req_len;
                        state_d = bus.req_write ? STORE : LOAD;
                    end
                end
            end
            STORE: begin
                addr_d = addr_q + ADDR_ONE;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    store_done_d = 1'b1;
                end
            end
            LOAD: begin
                // The response register doubles as the only buffer, so a beat only
                // advances when it is empty or being drained this cycle.
                if (!resp_valid_q || bus.resp_ready) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_rdata;
                    resp_last_d  = (cnt_q == '0);
                    addr_d       = addr_q + ADDR_ONE;
                    cnt_d        = cnt_q - CNT_ONE;
                    if (cnt_q == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            store_done_q <= 1'b0;
`ifdef LSU_FAULT_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            store_done_q <= store_done_d;
`ifdef LSU_FAULT_EN
            fault_q      <= fault_d;
`endif
        end
    end

    // Write enable decodes straight from state so reset drops it without waiting for a clock.
    assign mem_wen        = (state_q == STORE);
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign dbg_state      = state_q;
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_last  = resp_last_q;
    assign bus.store_done = store_done_q;
`ifdef LSU_FAULT_EN
    assign fault          = fault_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256x8 memory (comb read, sync write).
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  lsu_state_t        dbg_state;
`ifdef LSU_FAULT_EN
  logic              fault;
`endif

  load_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
`ifdef LSU_FAULT_EN
    ,
    .fault     (fault)
`endif
  );

  // ---------------- memory model + monitors ----------------
  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
  logic              tb_wen;
  logic [ADDR_W-1:0] tb_waddr;
  logic [DATA_W-1:0] tb_wdata;
  int                wen_cnt;
  int                sd_cnt;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    else if (tb_wen) mem[tb_waddr] <= tb_wdata;
  end

  always @(posedge clk) begin
    if (mem_wen) wen_cnt <= wen_cnt + 1;
    if (bus.store_done) sd_cnt <= sd_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int checks;
  int failures;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    tb_wen   = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    step();
    tb_wen   = 1'b0;
  endtask

  // Presents a request and returns 1 time unit after the accepting edge.
  task automatic do_req(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
    int n;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_len   = l;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      step();
      n++;
    end
    check("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  // Pops exp_q against the response channel with resp_ready held high; bounded.
  task automatic drain_load(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      if (bus.resp_valid) begin
        check({tag, "_data"}, {24'd0, bus.resp_data}, {24'd0, exp_q[0]});
        check({tag, "_last"}, {31'd0, bus.resp_last}, {31'd0, exp_q.size() == 1});
        void'(exp_q.pop_front());
      end
      step();
      n++;
    end
    check({tag, "_all_beats"}, exp_q.size(), 32'd0);
    check({tag, "_drained"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int base_wen;
  int base_sd;

  initial begin
    checks        = 0;
    failures      = 0;
    wen_cnt       = 0;
    sd_cnt        = 0;
    tb_wen        = 1'b0;
    tb_waddr      = '0;
    tb_wdata      = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    bus.resp_ready = 1'b1;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_state",      dbg_state, IDLE);
    check("rst_mem_wen",    {31'd0, mem_wen}, 32'd0);
    check("rst_mem_addr",   {24'd0, mem_addr}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_store_done", {31'd0, bus.store_done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single store 0x10 <= 0xA5
    base_wen = wen_cnt;
    base_sd  = sd_cnt;
    do_req(1'b1, 8'h10, 8'hA5, 4'd0);
    check("st1_wen",   {31'd0, mem_wen}, 32'd1);
    check("st1_addr",  {24'd0, mem_addr}, 32'h10);
    check("st1_wdata", {24'd0, mem_wdata}, 32'hA5);
    step();
    check("st1_wen_off", {31'd0, mem_wen}, 32'd0);
    check("st1_done",    {31'd0, bus.store_done}, 32'd1);
    check("st1_state",   dbg_state, IDLE);
    step();
    check("st1_done_pulse", {31'd0, bus.store_done}, 32'd0);
    check("st1_wen_cycles", wen_cnt - base_wen, 32'd1);
    check("st1_mem", {24'd0, mem[8'h10]}, 32'hA5);

    // Load it back
    do_req(1'b0, 8'h10, 8'h00, 4'd0);
    exp_q.push_back(8'hA5);
    drain_load("ld1");

    // Store burst 0x20..0x23 <= 0x3C, 0x24 must survive
    preload(8'h24, 8'h77);
    base_wen = wen_cnt;
    base_sd  = sd_cnt;
    do_req(1'b1, 8'h20, 8'h3C, 4'd3);
    for (int i = 0; i < 4; i++) begin
      check("stb_wen",  {31'd0, mem_wen}, 32'd1);
      check("stb_addr", {24'd0, mem_addr}, 32'h20 + i);
      step();
    end
    check("stb_wen_off", {31'd0, mem_wen}, 32'd0);
    step();
    check("stb_wen_cycles", wen_cnt - base_wen, 32'd4);
    check("stb_done_once",  sd_cnt - base_sd, 32'd1);
    for (int i = 0; i < 4; i++) check("stb_mem", {24'd0, mem[8'h20 + i]}, 32'h3C);
    check("stb_untouched", {24'd0, mem[8'h24]}, 32'h77);

    // Load burst with backpressure after the first beat
    for (int i = 0; i < 4; i++) preload(8'h40 + i[7:0], 8'(i + 1));
    bus.resp_ready = 1'b0;
    do_req(1'b0, 8'h40, 8'h00, 4'd3);
    check("bp_first_addr", {24'd0, mem_addr}, 32'h40);
    step();
    check("bp_v0", {31'd0, bus.resp_valid}, 32'd1);
    check("bp_d0", {24'd0, bus.resp_data}, 32'd1);
    check("bp_l0", {31'd0, bus.resp_last}, 32'd0);
    step();
    check("bp_hold1", {24'd0, bus.resp_data}, 32'd1);
    step();
    check("bp_hold2", {24'd0, bus.resp_data}, 32'd1);
    check("bp_hold_addr", {24'd0, mem_addr}, 32'h41);
    bus.resp_ready = 1'b1;
    step();
    check("bp_d1", {24'd0, bus.resp_data}, 32'd2);
    check("bp_l1", {31'd0, bus.resp_last}, 32'd0);
    step();
    check("bp_d2", {24'd0, bus.resp_data}, 32'd3);
    check("bp_l2", {31'd0, bus.resp_last}, 32'd0);
    step();
    check("bp_d3", {24'd0, bus.resp_data}, 32'd4);
    check("bp_l3", {31'd0, bus.resp_last}, 32'd1);
    check("bp_idle", dbg_state, IDLE);

    // Back-to-back: new load waits for the pending last byte
    bus.resp_ready = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 8'h42;
    bus.req_len    = 4'd0;
    bus.req_valid  = 1'b1;
    #1;
    check("b2b_blocked", {31'd0, bus.req_ready}, 32'd0);
    step();
    check("b2b_still_pending", {31'd0, bus.resp_valid}, 32'd1);
    check("b2b_data_held", {24'd0, bus.resp_data}, 32'd4);
    check("b2b_blocked2", {31'd0, bus.req_ready}, 32'd0);
    bus.resp_ready = 1'b1;
    step();
    check("b2b_consumed", {31'd0, bus.resp_valid}, 32'd0);
    check("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    check("b2b_accepted", dbg_state, LOAD);
    step();
    check("b2b_data", {24'd0, bus.resp_data}, 32'd3);
    check("b2b_last", {31'd0, bus.resp_last}, 32'd1);
    step();
    check("b2b_drained", {31'd0, bus.resp_valid}, 32'd0);

    // Wrap-around load 0xFE, 0xFF, 0x00
    preload(8'hFE, 8'h11);
    preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33);
    base_wen = wen_cnt;
    do_req(1'b0, 8'hFE, 8'h00, 4'd2);
`ifdef LSU_FAULT_EN
    check("wrap_fault",   {31'd0, fault}, 32'd1);
    check("wrap_state",   dbg_state, IDLE);
    check("wrap_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    step();
    check("wrap_fault_pulse", {31'd0, fault}, 32'd0);
    check("wrap_no_resp2",    {31'd0, bus.resp_valid}, 32'd0);
    step();
    check("wrap_no_resp3",    {31'd0, bus.resp_valid}, 32'd0);
`else
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    drain_load("wrap");
`endif
    check("wrap_no_wen", wen_cnt - base_wen, 32'd0);

    // Reset in the middle of an 8-beat store
    preload(8'h53, 8'hEE);
    base_sd = sd_cnt;
    do_req(1'b1, 8'h50, 8'h99, 4'd7);
    step();
    step();
    step();
    check("rms_mid_addr", {24'd0, mem_addr}, 32'h53);
    check("rms_mid_wen",  {31'd0, mem_wen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rms_wen_async", {31'd0, mem_wen}, 32'd0);
    check("rms_addr",      {24'd0, mem_addr}, 32'd0);
    check("rms_wdata",     {24'd0, mem_wdata}, 32'd0);
    check("rms_state",     dbg_state, IDLE);
    step();
    check("rms_done", {31'd0, bus.store_done}, 32'd0);
    for (int i = 0; i < 3; i++) check("rms_written", {24'd0, mem[8'h50 + i]}, 32'h99);
    check("rms_untouched", {24'd0, mem[8'h53]}, 32'hEE);
    check("rms_no_done", sd_cnt - base_sd, 32'd0);
    rst_n = 1'b1;
    step();
    check("rms_after_state", dbg_state, IDLE);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the core's execute stage and the 256x8 data memory.
- Accepts single- or multi-byte load/store requests over a valid/ready handshake.
- Drives the memory's write-enable, address and write-data inputs. The memory reads combinationally and writes synchronously.
- Returns load bytes on a registered, back-pressurable response channel. Store bursts are memset-style: one byte written to consecutive addresses.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data width.
- LEN_W, 4, burst-length field width; a burst is req_len+1 beats, so 1..16.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  store byte, written to every beat's address.
- req_len  in  LEN_W  beats minus one.
- resp_valid  out  1  load byte valid.
- resp_ready  in  1  consumer accepts resp_data.
- resp_data  out  DATA_W  loaded byte.
- resp_last  out  1  marks the final beat of a load burst.
- store_done  out  1  one-cycle pulse after the final store beat is written.
- mem_wen  out  1  to the data memory's write enable.
- mem_addr  out  ADDR_W  to the data memory's address.
- mem_wdata  out  DATA_W  to the data memory's write data.
- mem_rdata  in  DATA_W  from the data memory's read output (combinational).

Behaviour:
- Reset, asynchronous, rst_n=0:
  - State=IDLE; addr_q, wdata_q, cnt_q cleared.
  - resp_valid=0, resp_data=0, resp_last=0, store_done=0.
  - mem_wen=0 immediately (combinational from state); mem_addr=0, mem_wdata=0.
- States: IDLE, STORE, LOAD.
- IDLE:
  - req_ready = !resp_valid.
  - On handshake: latch addr_q=req_addr, wdata_q=req_wdata, cnt_q=req_len.
  - Go to STORE if req_write, else LOAD.
- STORE:
  - mem_wen=1, mem_addr=addr_q, mem_wdata=wdata_q; req_ready=0.
  - Each cycle: addr_q+=1 and cnt_q-=1.
  - When cnt_q==0: that beat writes, state goes to IDLE, and store_done pulses on the next cycle.
  - Latency: req_len+1 write cycles after acceptance.
- LOAD:
  - mem_wen=0, mem_addr=addr_q; req_ready=0.
  - Beat advances when !resp_valid || resp_ready. On advance:
    - resp_data<=mem_rdata, resp_valid<=1, resp_last<=(cnt_q==0).
    - addr_q+=1, cnt_q-=1.
    - After the last beat, go to IDLE.
  - When stalled (resp_valid && !resp_ready): addr, count and resp_data hold.
  - First byte is visible one cycle after acceptance; a stall-free burst delivers one byte per cycle.
- Response register:
  - resp_valid clears on resp_ready when no new beat is loaded the same cycle.
  - A simultaneous consume and load keeps resp_valid=1 with the new data.
- Address arithmetic: modulo 2**ADDR_W. 0xFF+1 wraps to 0x00 (only without LSU_FAULT_EN).
- A new request is not accepted until the final load byte is consumed (req_ready low while resp_valid).
- Reset mid-burst aborts the burst. Bytes already written remain; no store_done or resp_last is issued.

Optional Feature:
- Macro: LSU_FAULT_EN.
- Defined:
  - Adds output port fault (1 bit).
  - A request with req_addr + req_len > 2**ADDR_W-1 is accepted but performs no memory access. State stays IDLE and fault pulses one cycle later.
  - No resp_valid or store_done is issued for the faulting request.
- Undefined: no fault port; bursts wrap around the address space.

Decomposition:
- Package lsu_pkg holds:
  - state enum lsu_state_t {IDLE, STORE, LOAD};
  - default widths ADDR_W, DATA_W, LEN_W;
  - MEM_DEPTH.
- No sub-module. The beat counter and address incrementer are small enough to stay inline.

Test Plan:
- Single store: addr=0x10, wdata=0xA5, len=0 → mem_wen high exactly 1 cycle with mem_addr=0x10; store_done pulses next cycle; a later load of 0x10 returns 0xA5 with resp_last=1.
- Store burst: addr=0x20, wdata=0x3C, len=3 → writes 0x20..0x23 on 4 consecutive cycles; 0x24 untouched; store_done pulses once.
- Load burst with backpressure: preload 0x40..0x43 = 1,2,3,4, len=3, resp_ready low for 2 cycles after the first beat → bytes 1,2,3,4 in order, none dropped or duplicated; resp_last only on 4.
- Wrap: addr=0xFE, len=2, load → reads 0xFE, 0xFF, 0x00. With LSU_FAULT_EN: fault pulses, no resp_valid, no mem_wen.
- Reset mid-store: addr=0x50, len=7, rst_n low after the 3rd beat → mem_wen drops asynchronously; 0x50..0x52 written, 0x53.. unchanged; outputs at reset values.
- Back-to-back: load request held valid while the previous resp_valid is pending → req_ready=0 until resp consumed, then accepted in the next cycle.
